// File: rtl/uart_block_rx_pp.sv
// Ping-pong block receiver between the byte-level UART receiver and a block consumer.
// Bytes fill one bank while the other bank is read; supports sync framing, timeout close and drop accounting.
module uart_block_rx_pp #(
    parameter int         BLOCK_SIZE     = 129,
    parameter int         ADDR_W         = $clog2(BLOCK_SIZE),
    parameter int         CNT_W          = $clog2(BLOCK_SIZE + 1),
    parameter bit         SYNC_EN        = 1'b0,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic              consume,
    output logic              block_ready,
    output logic              rd_bank,
    output logic [CNT_W-1:0]  byte_count,
    output logic              partial,
    output logic              overrun,
    output logic [7:0]        drop_count,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(BLOCK_SIZE - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(BLOCK_SIZE);
    localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(BLOCK_SIZE);
    localparam logic [TMR_W-1:0]  TMR_LAST   =
        TMR_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    typedef enum logic {
        HUNT = 1'b0,
        FILL = 1'b1
    } state_t;

    localparam state_t START_STATE = SYNC_EN ? HUNT : FILL;

    state_t             state;
    logic               wr_bank;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [1:0]         full;
    logic [1:0]         part;
    logic [CNT_W-1:0]   count [2];
    logic [TMR_W-1:0]   timer;
    logic [7:0]         mem [2][BLOCK_SIZE];

    logic               in_fill;
    logic               store;
    logic               drop;
    logic               tmo_fire;
    logic               close;
    logic [CNT_W-1:0]   close_cnt;
    logic               take;

    assign in_fill   = (state == FILL);
    assign store     = rx_valid && in_fill && !full[wr_bank];
    assign drop      = rx_valid && in_fill && full[wr_bank];
    // A non-empty fill bank is never full, so the timer only runs on a bank being written.
    assign tmo_fire  = (TIMEOUT_CYCLES > 0) && in_fill && !rx_valid &&
                       (wr_ptr != '0) && (timer == TMR_LAST);
    assign close     = (store && (wr_ptr == LAST_PTR)) || tmo_fire;
    assign close_cnt = store ? FULL_CNT : CNT_W'(wr_ptr);
    assign take      = consume && full[rd_bank];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= START_STATE;
            wr_bank    <= 1'b0;
            wr_ptr     <= '0;
            full       <= '0;
            part       <= '0;
            count[0]   <= '0;
            count[1]   <= '0;
            timer      <= '0;
            rd_bank    <= 1'b0;
            overrun    <= 1'b0;
            drop_count <= '0;
        end else begin
            if (take) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
                overrun       <= 1'b0;
            end

            // Placed after the consume clear so a same-cycle drop leaves overrun set.
            if (drop) begin
                overrun <= 1'b1;
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end

            if (close) begin
                full[wr_bank]  <= 1'b1;
                count[wr_bank] <= close_cnt;
                part[wr_bank]  <= ~store;
                wr_bank        <= ~wr_bank;
                wr_ptr         <= '0;
                state          <= START_STATE;
            end else if (store) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end else if (state == HUNT && rx_valid && rx_byte == SYNC_BYTE) begin
                state <= FILL;
            end

            if (close || rx_valid) begin
                timer <= '0;
            end else if ((TIMEOUT_CYCLES > 0) && in_fill && (wr_ptr != '0)) begin
                timer <= timer + TMR_W'(1);
            end
        end
    end

    // NOTE: the bank storage has no reset; the full flags alone decide what is valid.
    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_bank][wr_ptr] <= rx_byte;
        end
    end

    assign block_ready = full[rd_bank];
    assign byte_count  = block_ready ? count[rd_bank] : '0;
    assign partial     = block_ready & part[rd_bank];
    assign rd_data     = ({1'b0, rd_addr} < ADDR_LIMIT) ? mem[rd_bank][rd_addr] : 8'h00;

endmodule

// File: tb/tb_uart_block_rx_pp.sv
// Scoreboard bench for uart_block_rx_pp: three 4-byte-block instances (plain, timeout, sync framing).
// Stimulus queues expected blocks; a monitor reads and consumes each block the DUT presents.
`timescale 1ns/1ps
module tb_uart_block_rx_pp;

    localparam int NDUT = 3;

    typedef struct {
        int              dut;
        logic            bank;
        int              cnt;
        logic            part;
        logic [3:0][7:0] data;
    } blk_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_valid    [NDUT];
    logic [7:0] rx_byte     [NDUT];
    logic       consume     [NDUT];
    logic [1:0] rd_addr     [NDUT];
    logic       block_ready [NDUT];
    logic       rd_bank     [NDUT];
    logic [2:0] byte_count  [NDUT];
    logic       partial     [NDUT];
    logic       overrun     [NDUT];
    logic [7:0] drop_count  [NDUT];
    logic [7:0] rd_data     [NDUT];
    logic       mon_en      [NDUT];

    blk_t exp_q [$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #20 clk = ~clk;

    uart_block_rx_pp #(.BLOCK_SIZE(4), .SYNC_EN(1'b0), .TIMEOUT_CYCLES(0)) u_plain (
        .clk(clk), .rst(rst), .rx_valid(rx_valid[0]), .rx_byte(rx_byte[0]),
        .consume(consume[0]), .block_ready(block_ready[0]), .rd_bank(rd_bank[0]),
        .byte_count(byte_count[0]), .partial(partial[0]), .overrun(overrun[0]),
        .drop_count(drop_count[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0])
    );

    uart_block_rx_pp #(.BLOCK_SIZE(4), .SYNC_EN(1'b0), .TIMEOUT_CYCLES(10)) u_tmo (
        .clk(clk), .rst(rst), .rx_valid(rx_valid[1]), .rx_byte(rx_byte[1]),
        .consume(consume[1]), .block_ready(block_ready[1]), .rd_bank(rd_bank[1]),
        .byte_count(byte_count[1]), .partial(partial[1]), .overrun(overrun[1]),
        .drop_count(drop_count[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1])
    );

    uart_block_rx_pp #(.BLOCK_SIZE(4), .SYNC_EN(1'b1), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(0)) u_sync (
        .clk(clk), .rst(rst), .rx_valid(rx_valid[2]), .rx_byte(rx_byte[2]),
        .consume(consume[2]), .block_ready(block_ready[2]), .rd_bank(rd_bank[2]),
        .byte_count(byte_count[2]), .partial(partial[2]), .overrun(overrun[2]),
        .drop_count(drop_count[2]), .rd_addr(rd_addr[2]), .rd_data(rd_data[2])
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic void expect_blk(input int dut, input logic bank, input int cnt, input logic part,
                                       input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3);
        blk_t e;
        e.dut     = dut;
        e.bank    = bank;
        e.cnt     = cnt;
        e.part    = part;
        e.data[0] = b0;
        e.data[1] = b1;
        e.data[2] = b2;
        e.data[3] = b3;
        exp_q.push_back(e);
    endfunction

    // Presents one byte for exactly one clock; call and return on a falling edge.
    task automatic send(input int i, input logic [7:0] b);
        rx_byte[i]  = b;
        rx_valid[i] = 1'b1;
        @(negedge clk);
        rx_valid[i] = 1'b0;
    endtask

    task automatic apply_reset();
        for (int i = 0; i < NDUT; i++) begin
            mon_en[i]   = 1'b0;
            rx_valid[i] = 1'b0;
        end
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("rst_block_ready%0d", i), block_ready[i], 0);
            check($sformatf("rst_rd_bank%0d", i), rd_bank[i], 0);
            check($sformatf("rst_byte_count%0d", i), byte_count[i], 0);
            check($sformatf("rst_partial%0d", i), partial[i], 0);
            check($sformatf("rst_overrun%0d", i), overrun[i], 0);
            check($sformatf("rst_drop_count%0d", i), drop_count[i], 0);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin : monitor
        blk_t e;
        for (int i = 0; i < NDUT; i++) begin
            consume[i] = 1'b0;
            rd_addr[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NDUT; i++) begin
                if (rst && mon_en[i] && block_ready[i]) begin
                    check($sformatf("blk_queued%0d", i), exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("blk_dut", i, e.dut);
                        check("blk_bank", rd_bank[i], e.bank);
                        check("blk_count", byte_count[i], e.cnt);
                        check("blk_partial", partial[i], e.part);
                        for (int a = 0; a < e.cnt; a++) begin
                            rd_addr[i] = 2'(a);
                            #1;
                            check($sformatf("blk_data%0d[%0d]", i, a), rd_data[i], e.data[a]);
                        end
                    end
                    consume[i] = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NDUT; i++) consume[i] = 1'b0;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        for (int i = 0; i < NDUT; i++) begin
            rx_valid[i] = 1'b0;
            rx_byte[i]  = 8'h00;
            mon_en[i]   = 1'b0;
        end
        repeat (2) @(negedge clk);
        apply_reset();

        // Single full block, one-cycle close latency.
        mon_en[0] = 1'b1;
        expect_blk(0, 1'b0, 4, 1'b0, 8'h01, 8'h02, 8'h03, 8'h04);
        send(0, 8'h01);
        send(0, 8'h02);
        send(0, 8'h03);
        check("t1_not_ready", block_ready[0], 0);
        send(0, 8'h04);
        check("t1_latency", block_ready[0], 1);
        check("t1_rd_bank", rd_bank[0], 0);
        drain("t1_drain");
        check("t1_bank_toggled", rd_bank[0], 1);
        check("t1_released", block_ready[0], 0);

        // Two blocks back to back with no consume in between.
        apply_reset();
        expect_blk(0, 1'b0, 4, 1'b0, 8'h10, 8'h11, 8'h12, 8'h13);
        expect_blk(0, 1'b1, 4, 1'b0, 8'h14, 8'h15, 8'h16, 8'h17);
        for (int b = 0; b < 8; b++) send(0, 8'(8'h10 + b));
        check("t2_ready", block_ready[0], 1);
        check("t2_rd_bank", rd_bank[0], 0);
        check("t2_count", byte_count[0], 4);
        mon_en[0] = 1'b1;
        drain("t2_drain");

        // Both banks full: drops, sticky overrun, saturating counter survives consume.
        apply_reset();
        expect_blk(0, 1'b0, 4, 1'b0, 8'h20, 8'h21, 8'h22, 8'h23);
        expect_blk(0, 1'b1, 4, 1'b0, 8'h24, 8'h25, 8'h26, 8'h27);
        for (int b = 0; b < 8; b++) send(0, 8'(8'h20 + b));
        send(0, 8'h30);
        send(0, 8'h31);
        send(0, 8'h32);
        check("t3_overrun", overrun[0], 1);
        check("t3_drop_count", drop_count[0], 3);
        mon_en[0] = 1'b1;
        drain("t3_drain");
        check("t3_overrun_cleared", overrun[0], 0);
        check("t3_drop_kept", drop_count[0], 3);
        expect_blk(0, 1'b0, 4, 1'b0, 8'h40, 8'h41, 8'h42, 8'h43);
        for (int b = 0; b < 4; b++) send(0, 8'(8'h40 + b));
        drain("t3_refill_drain");

        // Timeout closes a partial block exactly ten cycles after the last byte.
        apply_reset();
        mon_en[1] = 1'b1;
        repeat (15) @(negedge clk);
        check("t4_empty_no_timeout", block_ready[1], 0);
        expect_blk(1, 1'b0, 2, 1'b1, 8'h50, 8'h51, 8'h00, 8'h00);
        send(1, 8'h50);
        send(1, 8'h51);
        repeat (9) @(negedge clk);
        check("t4_before_timeout", block_ready[1], 0);
        @(negedge clk);
        check("t4_at_timeout", block_ready[1], 1);
        drain("t4_drain");
        expect_blk(1, 1'b1, 1, 1'b1, 8'h52, 8'h00, 8'h00, 8'h00);
        send(1, 8'h52);
        drain("t4_second_drain");

        // Sync framing: junk before the sync byte and unframed bytes are discarded.
        apply_reset();
        mon_en[2] = 1'b1;
        expect_blk(2, 1'b0, 4, 1'b0, 8'h01, 8'h02, 8'h03, 8'h04);
        send(2, 8'h33);
        send(2, 8'hA5);
        for (int b = 1; b <= 4; b++) send(2, 8'(b));
        drain("t5_drain");
        check("t5_no_drop", drop_count[2], 0);
        send(2, 8'h05);
        repeat (3) @(negedge clk);
        check("t5_unframed_ignored", block_ready[2], 0);
        check("t5_unframed_no_drop", drop_count[2], 0);
        expect_blk(2, 1'b1, 4, 1'b0, 8'h06, 8'h07, 8'h08, 8'h09);
        send(2, 8'hA5);
        for (int b = 6; b <= 9; b++) send(2, 8'(b));
        drain("t5_second_drain");

        // Reset mid-fill discards the ready bank and the partial fill.
        apply_reset();
        for (int b = 0; b < 6; b++) send(0, 8'(8'h60 + b));
        check("t6_pre_ready", block_ready[0], 1);
        check("t6_pre_count", byte_count[0], 4);
        apply_reset();
        mon_en[0] = 1'b1;
        expect_blk(0, 1'b0, 4, 1'b0, 8'h80, 8'h81, 8'h82, 8'h83);
        for (int b = 0; b < 4; b++) send(0, 8'(8'h80 + b));
        drain("t6_drain");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
